// File: rtl/bpu_port_scheduler.sv
// Arbitrates the single BTB/local-predictor port between fetch lookups and
// queued execute-side updates; the port controls come straight from registers.
module bpu_port_scheduler #(
  parameter int UPD_DEPTH  = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         lk_req,
  input  logic [23:0]                  lk_inst,
  input  logic                         lk_cond,
  output logic                         lk_gnt,
  input  logic                         up_valid,
  input  logic [23:0]                  up_inst,
  input  logic                         up_cond,
  input  logic                         up_taken,
  input  logic [31:0]                  up_target,
  output logic                         up_ready,
  output logic                         read_write,
  output logic                         buffer_select,
  output logic                         branch_predictor_select,
  output logic [23:0]                  br_inst,
  output logic [31:0]                  br_taddr_exe,
  output logic                         prediction_valid_exe,
  output logic [4:0]                   LHT_index,
  output logic [$clog2(UPD_DEPTH):0]   q_count
);

  localparam int PW = $clog2(UPD_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(UPD_DEPTH);
  localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);

  typedef struct packed {
    logic [23:0] inst;
    logic        cond;
    logic        taken;
    logic [31:0] target;
  } upd_entry_t;

  upd_entry_t        mem [UPD_DEPTH];
  upd_entry_t        head;

  logic [PW-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]     rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]     count_reg, count_next;
  logic [SW-1:0]     starve_reg, starve_next;

  logic              rw_reg, rw_next;
  logic              bs_reg, bs_next;
  logic              bps_reg, bps_next;
  logic [23:0]       inst_reg, inst_next;
  logic [31:0]       taddr_reg, taddr_next;
  logic              pv_reg, pv_next;

  logic              q_empty, q_full, push, upd_gnt;

  assign q_empty  = (count_reg == '0);
  assign q_full   = (count_reg == DEPTH_C);
  assign up_ready = !rst && !q_full;
  assign push     = up_valid && up_ready;

  // Updates win when fetch is quiet, the queue is full, or fetch has starved them long enough.
  assign upd_gnt  = !rst && !q_empty && (!lk_req || q_full || (starve_reg == STARVE_C));
  assign lk_gnt   = !rst && lk_req && !upd_gnt;

  assign head     = mem[rd_ptr_reg];

  // Queue storage carries no reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= '{inst: up_inst, cond: up_cond, taken: up_taken, target: up_target};
    end
  end

  always_comb begin
    wr_ptr_next = push    ? wr_ptr_reg + PW'(1) : wr_ptr_reg;
    rd_ptr_next = upd_gnt ? rd_ptr_reg + PW'(1) : rd_ptr_reg;

    count_next = count_reg;
    case ({push, upd_gnt})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase

    starve_next = starve_reg;
    if (q_empty || upd_gnt) begin
      starve_next = '0;
    end else if (lk_gnt && (starve_reg != STARVE_C)) begin
      starve_next = starve_reg + SW'(1);
    end
  end

  always_comb begin
    rw_next    = 1'b1;
    bs_next    = 1'b0;
    bps_next   = 1'b0;
    inst_next  = inst_reg;
    taddr_next = taddr_reg;
    pv_next    = pv_reg;
    if (upd_gnt) begin
      rw_next    = 1'b0;
      bs_next    = 1'b1;
      bps_next   = head.cond;
      inst_next  = head.inst;
      taddr_next = head.target;
      pv_next    = head.taken;
    end else if (lk_gnt) begin
      bs_next    = 1'b1;
      bps_next   = lk_cond;
      inst_next  = lk_inst;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      starve_reg <= '0;
      rw_reg     <= 1'b1;
      bs_reg     <= 1'b0;
      bps_reg    <= 1'b0;
      inst_reg   <= '0;
      taddr_reg  <= '0;
      pv_reg     <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      starve_reg <= starve_next;
      rw_reg     <= rw_next;
      bs_reg     <= bs_next;
      bps_reg    <= bps_next;
      inst_reg   <= inst_next;
      taddr_reg  <= taddr_next;
      pv_reg     <= pv_next;
    end
  end

  assign read_write              = rw_reg;
  assign buffer_select           = bs_reg;
  assign branch_predictor_select = bps_reg;
  assign br_inst                 = inst_reg;
  assign br_taddr_exe            = taddr_reg;
  assign prediction_valid_exe    = pv_reg;
  assign LHT_index               = inst_reg[4:0];
  assign q_count                 = count_reg;

endmodule

// File: tb/tb_bpu_port_scheduler.sv
// Bench for bpu_port_scheduler: lookup vector table, scoreboarded update writes,
// and directed starvation / full-queue / wrap / reset sequences.
module tb_bpu_port_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, lk_req, lk_cond, up_valid, up_cond, up_taken;
  logic [23:0] lk_inst, up_inst;
  logic [31:0] up_target;

  logic        lk_gnt, up_ready, read_write, buffer_select, branch_predictor_select, prediction_valid_exe;
  logic [23:0] br_inst;
  logic [31:0] br_taddr_exe;
  logic [4:0]  LHT_index;
  logic [2:0]  q_count;

  logic        lk_gnt_b, up_ready_b, read_write_b, buffer_select_b, branch_predictor_select_b, prediction_valid_exe_b;
  logic [23:0] br_inst_b;
  logic [31:0] br_taddr_exe_b;
  logic [4:0]  LHT_index_b;
  logic [2:0]  q_count_b;

  bpu_port_scheduler #(.UPD_DEPTH(4), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst), .lk_req(lk_req), .lk_inst(lk_inst), .lk_cond(lk_cond), .lk_gnt(lk_gnt),
    .up_valid(up_valid), .up_inst(up_inst), .up_cond(up_cond), .up_taken(up_taken),
    .up_target(up_target), .up_ready(up_ready), .read_write(read_write),
    .buffer_select(buffer_select), .branch_predictor_select(branch_predictor_select),
    .br_inst(br_inst), .br_taddr_exe(br_taddr_exe), .prediction_valid_exe(prediction_valid_exe),
    .LHT_index(LHT_index), .q_count(q_count)
  );

  bpu_port_scheduler #(.UPD_DEPTH(4), .STARVE_MAX(7)) dut7 (
    .clk(clk), .rst(rst), .lk_req(lk_req), .lk_inst(lk_inst), .lk_cond(lk_cond), .lk_gnt(lk_gnt_b),
    .up_valid(up_valid), .up_inst(up_inst), .up_cond(up_cond), .up_taken(up_taken),
    .up_target(up_target), .up_ready(up_ready_b), .read_write(read_write_b),
    .buffer_select(buffer_select_b), .branch_predictor_select(branch_predictor_select_b),
    .br_inst(br_inst_b), .br_taddr_exe(br_taddr_exe_b), .prediction_valid_exe(prediction_valid_exe_b),
    .LHT_index(LHT_index_b), .q_count(q_count_b)
  );

  typedef struct packed {
    logic [23:0] inst;
    logic        cond;
    logic        taken;
    logic [31:0] target;
  } upd_t;

  typedef struct {
    logic        req;
    logic [23:0] inst;
    logic        cond;
    logic        exp_gnt;
    logic        exp_bs;
    logic        exp_bps;
    logic [23:0] exp_inst;
  } vec_t;

  upd_t sb[$];
  vec_t vecs[6];
  int   passed = 0;
  int   total  = 0;

  logic       gnt_s, gnt_b_s, rdy_b_s;
  logic [2:0] qb_s;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    else passed++;
  endtask

  // One clock: sample combinational outputs at negedge, log accepted pushes,
  // then after the edge compare any write pulse against the scoreboard head.
  task automatic step();
    upd_t e, got;
    @(negedge clk);
    gnt_s   = lk_gnt;
    gnt_b_s = lk_gnt_b;
    rdy_b_s = up_ready_b;
    qb_s    = q_count_b;
    if (up_valid && up_ready) begin
      e = {up_inst, up_cond, up_taken, up_target};
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!read_write) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL sb_unexpected_write: got write target 0x%0h, required no write", br_taddr_exe);
      end else begin
        e   = sb.pop_front();
        got = {br_inst, branch_predictor_select, prediction_valid_exe, br_taddr_exe};
        chk("sb_write_entry", 64'(got), 64'(e));
        chk("sb_write_bs", 64'(buffer_select), 64'd1);
      end
    end
    $display("cyc t=%0t gnt=%0b rw=%0b bs=%0b bps=%0b inst=%06h taddr=%08h q=%0d q7=%0d",
             $time, gnt_s, read_write, buffer_select, branch_predictor_select, br_inst,
             br_taddr_exe, q_count, q_count_b);
  endtask

  task automatic do_reset();
    rst = 1'b1; lk_req = 1'b0; up_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_lk_gnt"}, 64'(lk_gnt), 64'd0);
    chk({tag, "_up_ready"}, 64'(up_ready), 64'd0);
    chk({tag, "_rw"}, 64'(read_write), 64'd1);
    chk({tag, "_bs"}, 64'(buffer_select), 64'd0);
    chk({tag, "_bps"}, 64'(branch_predictor_select), 64'd0);
    chk({tag, "_br_inst"}, 64'(br_inst), 64'd0);
    chk({tag, "_taddr"}, 64'(br_taddr_exe), 64'd0);
    chk({tag, "_pve"}, 64'(prediction_valid_exe), 64'd0);
    chk({tag, "_lht"}, 64'(LHT_index), 64'd0);
    chk({tag, "_q"}, 64'(q_count), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_g [12];
    exp_g = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    vecs[0] = '{1'b1, 24'h123456, 1'b1, 1'b1, 1'b1, 1'b1, 24'h123456};
    vecs[1] = '{1'b1, 24'hFEDCBA, 1'b0, 1'b1, 1'b1, 1'b0, 24'hFEDCBA};
    vecs[2] = '{1'b0, 24'h000000, 1'b1, 1'b0, 1'b0, 1'b0, 24'hFEDCBA};
    vecs[3] = '{1'b1, 24'h00001F, 1'b1, 1'b1, 1'b1, 1'b1, 24'h00001F};
    vecs[4] = '{1'b0, 24'hAAAAAA, 1'b0, 1'b0, 1'b0, 1'b0, 24'h00001F};
    vecs[5] = '{1'b1, 24'h7FFFE0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h7FFFE0};

    // Reset held from time zero with requests active: everything gated off.
    rst = 1'b1; lk_req = 1'b1; lk_inst = 24'h5A5A5A; lk_cond = 1'b1;
    up_valid = 1'b1; up_inst = 24'h111111; up_cond = 1'b1; up_taken = 1'b1; up_target = 32'h99;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst_hold");
    rst = 1'b0; lk_req = 1'b0; up_valid = 1'b0;
    #1;
    chk("rel_up_ready", 64'(up_ready), 64'd1);
    chk("rel_q", 64'(q_count), 64'd0);

    // Lookup-only vector table with an empty queue.
    for (int i = 0; i < 6; i++) begin
      lk_req = vecs[i].req; lk_inst = vecs[i].inst; lk_cond = vecs[i].cond;
      step();
      chk($sformatf("vec%0d_gnt", i), 64'(gnt_s), 64'(vecs[i].exp_gnt));
      chk($sformatf("vec%0d_rw", i), 64'(read_write), 64'd1);
      chk($sformatf("vec%0d_bs", i), 64'(buffer_select), 64'(vecs[i].exp_bs));
      chk($sformatf("vec%0d_bps", i), 64'(branch_predictor_select), 64'(vecs[i].exp_bps));
      chk($sformatf("vec%0d_inst", i), 64'(br_inst), 64'(vecs[i].exp_inst));
      chk($sformatf("vec%0d_lht", i), 64'(LHT_index), 64'(vecs[i].exp_inst[4:0]));
    end

    // Lone update: push, grant next cycle, write pulse one cycle after that.
    lk_req = 1'b0; up_valid = 1'b1; up_inst = 24'h00ABC1; up_cond = 1'b1; up_taken = 1'b1; up_target = 32'h40;
    step();
    up_valid = 1'b0;
    chk("lone_no_bypass_rw", 64'(read_write), 64'd1);
    chk("lone_q1", 64'(q_count), 64'd1);
    step();
    chk("lone_lk_gnt", 64'(gnt_s), 64'd0);
    chk("lone_rw", 64'(read_write), 64'd0);
    chk("lone_bs", 64'(buffer_select), 64'd1);
    chk("lone_bps", 64'(branch_predictor_select), 64'd1);
    chk("lone_inst", 64'(br_inst), 64'h00ABC1);
    chk("lone_lht", 64'(LHT_index), 64'd1);
    chk("lone_taddr", 64'(br_taddr_exe), 64'h40);
    chk("lone_pve", 64'(prediction_valid_exe), 64'd1);
    chk("lone_q0", 64'(q_count), 64'd0);
    step();
    chk("lone_idle_rw", 64'(read_write), 64'd1);
    chk("lone_idle_bs", 64'(buffer_select), 64'd0);
    chk("lone_idle_taddr", 64'(br_taddr_exe), 64'h40);
    chk("lone_idle_q", 64'(q_count), 64'd0);

    // Starvation with STARVE_MAX=3 and continuous lookups.
    do_reset();
    lk_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      lk_inst = 24'h100000 + 24'(i); lk_cond = i[0];
      up_valid = (i < 2); up_inst = 24'hC0DE00 + 24'(i); up_cond = 1'b1; up_taken = i[0];
      up_target = 32'h1000 + 32'(i);
      step();
      chk($sformatf("starve_gnt%0d", i), 64'(gnt_s), 64'(exp_g[i]));
      chk($sformatf("starve_rw%0d", i), 64'(read_write), 64'(exp_g[i]));
    end

    // Full queue on the STARVE_MAX=7 instance.
    do_reset();
    lk_req = 1'b1; lk_cond = 1'b0;
    for (int i = 0; i < 4; i++) begin
      up_valid = 1'b1; up_inst = 24'h2000 + 24'(i); up_cond = 1'b0; up_taken = 1'b1;
      up_target = 32'h201 + 32'(i);
      step();
      chk($sformatf("full_q_b%0d", i), 64'(q_count_b), 64'(i + 1));
      chk($sformatf("full_rdy_b%0d", i), 64'(up_ready_b), 64'(i < 3));
    end
    up_inst = 24'h2004; up_target = 32'h205;
    step();
    chk("full_rdy_b_blocked", 64'(rdy_b_s), 64'd0);
    chk("full_q_b_hold", 64'(qb_s), 64'd4);
    chk("full_gnt_b_upd", 64'(gnt_b_s), 64'd0);
    chk("full_q_b_popped", 64'(q_count_b), 64'd3);
    chk("full_rdy_b_back", 64'(up_ready_b), 64'd1);
    chk("full_rw_b_write", 64'(read_write_b), 64'd0);
    chk("full_taddr_b", 64'(br_taddr_exe_b), 64'h201);
    step();
    chk("full_q_b_repush", 64'(q_count_b), 64'd4);
    up_valid = 1'b0; lk_req = 1'b0;
    repeat (6) step();
    chk("full_drain_q_b", 64'(q_count_b), 64'd0);
    chk("full_drain_q", 64'(q_count), 64'd0);

    // Simultaneous push/pop at occupancy 2 across pointer wrap.
    do_reset();
    lk_req = 1'b1; up_valid = 1'b1; up_cond = 1'b1; up_taken = 1'b0;
    up_inst = 24'h300001; up_target = 32'd1;
    step();
    up_inst = 24'h300002; up_target = 32'd2;
    step();
    chk("wrap_fill_q", 64'(q_count), 64'd2);
    lk_req = 1'b0;
    for (int k = 3; k <= 8; k++) begin
      up_inst = 24'h300000 + 24'(k); up_target = 32'(k);
      step();
      chk($sformatf("wrap_q_k%0d", k), 64'(q_count), 64'd2);
      chk($sformatf("wrap_taddr_k%0d", k), 64'(br_taddr_exe), 64'(k - 2));
    end
    up_valid = 1'b0;
    step();
    chk("wrap_taddr7", 64'(br_taddr_exe), 64'd7);
    chk("wrap_q1", 64'(q_count), 64'd1);
    step();
    chk("wrap_taddr8", 64'(br_taddr_exe), 64'd8);
    chk("wrap_q0", 64'(q_count), 64'd0);

    // Reset asserted mid-cycle with three entries queued.
    do_reset();
    lk_req = 1'b1; lk_inst = 24'h654321; lk_cond = 1'b1;
    for (int i = 0; i < 3; i++) begin
      up_valid = 1'b1; up_inst = 24'h600000 + 24'(i); up_target = 32'h600 + 32'(i);
      step();
    end
    chk("mid_q_pre", 64'(q_count), 64'd3);
    chk("mid_bs_pre", 64'(buffer_select), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("mid_rst");
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0; lk_req = 1'b0; up_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("post_rst_rw%0d", i), 64'(read_write), 64'd1);
      chk($sformatf("post_rst_bs%0d", i), 64'(buffer_select), 64'd0);
      chk($sformatf("post_rst_q%0d", i), 64'(q_count), 64'd0);
    end
    chk("post_rst_up_ready", 64'(up_ready), 64'd1);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bpu_port_scheduler.md
# bpu_port_scheduler

Sequences the shared, single-ported branch-prediction resources (branch target buffer and local-history branch predictor) in the fetch stage. Each cycle it decides whether the port serves a fetch-side lookup or an execute-side update. Resolved branch outcomes from execute are buffered in an update queue, and the scheduler drives the port control, key, target and outcome signals from a register stage. A starvation limit guarantees that execute-side updates are eventually written even while fetch issues back-to-back lookups.

## Interface
Parameters:
- UPD_DEPTH, 4: update queue depth; must be a power of 2, at least 2.
- STARVE_MAX, 3: maximum consecutive lookup grants while the queue is non-empty; must be at least 1.

Ports:
- clk  in  1  single clock; all state on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- lk_req  in  1  fetch lookup request; held until granted.
- lk_inst  in  24  lookup key: instruction[31:8].
- lk_cond  in  1  1 = conditional branch (predictor read needed); 0 = JAL/JALR.
- lk_gnt  out  1  combinational; lookup accepted this cycle.
- up_valid  in  1  resolved-branch push from execute.
- up_inst  in  24  resolved instruction[31:8].
- up_cond  in  1  1 = conditional (update predictor).
- up_taken  in  1  resolved direction.
- up_target  in  32  resolved target address.
- up_ready  out  1  queue not full; a push occurs when up_valid && up_ready.
- read_write  out  1  registered; 1 = read, 0 = write.
- buffer_select  out  1  registered; BTB enable.
- branch_predictor_select  out  1  registered; predictor enable.
- br_inst  out  24  registered port key.
- br_taddr_exe  out  32  registered write target.
- prediction_valid_exe  out  1  registered write outcome.
- LHT_index  out  5  registered; always equals br_inst[4:0].
- q_count  out  clog2(UPD_DEPTH)+1  registered queue occupancy.

## Operation
- The update queue is a circular FIFO with read and write pointers that wrap modulo UPD_DEPTH.
  - Each entry holds {inst, cond, taken, target}.
  - There is no bypass: an entry pushed at edge N can be granted no earlier than the cycle after edge N.
- Grant decision, combinational, at most one grant per cycle:
  - Force update when the queue is non-empty AND (lk_req=0 OR q_count==UPD_DEPTH OR starve_cnt==STARVE_MAX).
  - Otherwise, when lk_req=1, grant the lookup: lk_gnt=1.
  - Otherwise the port is idle.
- starve_cnt:
  - +1 on each lookup grant while the queue is non-empty.
  - Cleared on an update grant.
  - Cleared on any cycle the queue is empty.
  - Saturates at STARVE_MAX.
- Port register loading, at the edge ending the decision cycle:
  - Lookup grant: read_write=1, buffer_select=1, branch_predictor_select=lk_cond, br_inst=lk_inst; br_taddr_exe and prediction_valid_exe are held.
  - Update grant: read_write=0, buffer_select=1, branch_predictor_select=head.cond, br_inst=head.inst, br_taddr_exe=head.target, prediction_valid_exe=head.taken. The head entry is popped.
  - Idle: read_write=1, buffer_select=0, branch_predictor_select=0; the other port registers are held.
- Queue occupancy:
  - Push and pop in the same cycle leaves q_count unchanged.
  - up_ready = (q_count != UPD_DEPTH), driven from the registered count.
  - When the queue is full, up_valid is ignored and no entry is lost; execute must hold the push.

## Timing
- Reset values, asserted asynchronously:
  - read_write=1; buffer_select=0; branch_predictor_select=0.
  - br_inst=0, br_taddr_exe=0, prediction_valid_exe=0, LHT_index=0.
  - q_count=0, pointers=0, starve_cnt=0.
- While rst=1: lk_gnt=0 and up_ready=0.
- Reset mid-operation discards all queued entries. The port reads idle from the first cycle after reset release.
- Lookup latency: lk_gnt in cycle N; port signals valid in cycle N+1 for exactly one cycle unless granted again.
- Update latency with no lookup contention: push at edge N; granted in the cycle after edge N; port write visible in the cycle after edge N+1.
- Worst-case update wait with continuous lookups is STARVE_MAX lookup grants, then the update.
- Each grant drives the port for one cycle; a write pulse is never stretched.

## Test plan
- Reset check: assert rst mid-cycle. All outputs take the listed reset values immediately, with lk_gnt=0 and up_ready=0; after release, up_ready=1 and q_count=0.
- Lone update: push inst=0x00ABC1, cond=1, taken=1, target=0x40 with lk_req=0.
  - Two cycles later: read_write=0, buffer_select=1, branch_predictor_select=1, br_inst=0x00ABC1, LHT_index=1, br_taddr_exe=0x40, prediction_valid_exe=1 for one cycle.
  - Then idle with q_count=0.
- Starvation (STARVE_MAX=3): lk_req held high, then 2 updates pushed.
  - Grant pattern: L,L,L,U,L,L,L,U, then continuous L.
  - lk_gnt=0 exactly in the two U cycles.
- Full queue (UPD_DEPTH=4, STARVE_MAX=7): lk_req high with 4 pushes.
  - up_ready drops to 0 after the 4th push, and a 5th up_valid leaves q_count=4.
  - The next cycle grants U and lk_gnt=0; up_ready returns to 1 after the pop.
- Simultaneous push and pop with q_count=2: q_count stays 2 and the FIFO order is preserved across pointer wrap (8 pushes/pops, targets 1..8 emitted in order).
- Reset mid-operation with q_count=3: q_count=0 at once, and no write pulse (read_write=0) appears after release.
